ysyx_25030077_wb_control: RTL

YSYX_25030077_WB_CONTROL -- requirements
Module: ysyx_25030077_WB_CONTROL

---
 rtl/ysyx_25030077_wb_control.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/ysyx_25030077_wb_control.sv
// Writeback control: retires one instruction per transfer and drives the register-file write port.
// Latency: non-load writes one cycle after acceptance; load writes one cycle after rvalid is sampled in WAIT_MEM.
// Backpressure: io_in_ready only in IDLE, so at most one instruction per 2 cycles (longer for loads).
module ysyx_25030077_wb_control (
    input  logic        clock,
    input  logic        reset,
    input  logic        io_in_valid,
    output logic        io_in_ready,
    input  logic [1:0]  io_wb_sel,
    input  logic [4:0]  io_rd,
    input  logic [31:0] io_alu_result,
    input  logic [31:0] io_pc_count,
    input  logic [2:0]  io_funct3,
    input  logic        io_mem_rvalid,
    input  logic [31:0] io_mem_rdata,
    output logic        io_rf_wen,
    output logic [4:0]  io_rf_waddr,
    output logic [31:0] io_rf_wdata,
    output logic        io_done
);

    localparam logic [1:0] SEL_ALU  = 2'd0;
    localparam logic [1:0] SEL_MEM  = 2'd1;
    localparam logic [1:0] SEL_PC4  = 2'd2;
    localparam logic [1:0] SEL_NONE = 2'd3;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_MEM = 2'd1,
        WRITE    = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [4:0]  lat_rd;
    logic [1:0]  lat_wb_sel;
    logic [2:0]  lat_funct3;
    logic [1:0]  lat_addr_lo;
    logic [31:0] lat_alu;
    logic [31:0] lat_pc;

    logic        accept;
    logic [4:0]  op_rd;
    logic [1:0]  op_sel;
    logic [2:0]  op_funct3;
    logic [1:0]  op_addr_lo;
    logic [31:0] op_alu;
    logic [31:0] op_pc;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_val;
    logic [31:0] wdata_nxt;
    logic        wen_nxt;

    assign io_in_ready = (state == IDLE);
    assign accept      = io_in_valid && (state == IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (accept) state_nxt = (io_wb_sel == SEL_MEM) ? WAIT_MEM : WRITE;
            WAIT_MEM: if (io_mem_rvalid) state_nxt = WRITE;
            WRITE:    state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Operands come straight from the inputs on the accepting edge, otherwise from the latched copy.
    always_comb begin
        op_rd      = lat_rd;
        op_sel     = lat_wb_sel;
        op_funct3  = lat_funct3;
        op_addr_lo = lat_addr_lo;
        op_alu     = lat_alu;
        op_pc      = lat_pc;
        if (state == IDLE) begin
            op_rd      = io_rd;
            op_sel     = io_wb_sel;
            op_funct3  = io_funct3;
            op_addr_lo = io_alu_result[1:0];
            op_alu     = io_alu_result;
            op_pc      = io_pc_count;
        end
    end

    always_comb begin
        ld_byte = 8'h00;
        case (op_addr_lo)
            2'd0:    ld_byte = io_mem_rdata[7:0];
            2'd1:    ld_byte = io_mem_rdata[15:8];
            2'd2:    ld_byte = io_mem_rdata[23:16];
            default: ld_byte = io_mem_rdata[31:24];
        endcase
        ld_half = op_addr_lo[1] ? io_mem_rdata[31:16] : io_mem_rdata[15:0];
        ld_val  = io_mem_rdata;
        case (op_funct3)
            3'b000:  ld_val = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_val = {24'h0, ld_byte};
            3'b001:  ld_val = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_val = {16'h0, ld_half};
            default: ld_val = io_mem_rdata;
        endcase
    end

    always_comb begin
        wdata_nxt = 32'h0;
        case (op_sel)
            SEL_ALU:  wdata_nxt = op_alu;
            SEL_MEM:  wdata_nxt = ld_val;
            SEL_PC4:  wdata_nxt = op_pc + 32'd4;
            default:  wdata_nxt = 32'h0;
        endcase
        wen_nxt = (state_nxt == WRITE) && (op_rd != 5'd0) && (op_sel != SEL_NONE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lat_rd      <= 5'd0;
            lat_wb_sel  <= 2'd0;
            lat_funct3  <= 3'd0;
            lat_addr_lo <= 2'd0;
            lat_alu     <= 32'h0;
            lat_pc      <= 32'h0;
        end else if (accept) begin
            lat_rd      <= io_rd;
            lat_wb_sel  <= io_wb_sel;
            lat_funct3  <= io_funct3;
            lat_addr_lo <= io_alu_result[1:0];
            lat_alu     <= io_alu_result;
            lat_pc      <= io_pc_count;
        end
    end

    // Write port is loaded on the edge entering WRITE and cleared on the edge leaving it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            io_rf_wen   <= 1'b0;
            io_rf_waddr <= 5'd0;
            io_rf_wdata <= 32'h0;
            io_done     <= 1'b0;
        end else if (state_nxt == WRITE) begin
            io_rf_wen   <= wen_nxt;
            io_rf_waddr <= op_rd;
            io_rf_wdata <= wdata_nxt;
            io_done     <= 1'b1;
        end else begin
            io_rf_wen   <= 1'b0;
            io_rf_waddr <= 5'd0;
            io_rf_wdata <= 32'h0;
            io_done     <= 1'b0;
        end
    end

endmodule
